// File: rtl/editing_accel_pkg.sv
// Shared constants for the editing_accel input stage: stream geometry and FSM state codes.
package editing_accel_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned FRAME_LEN = 800;
  localparam int unsigned ADDR_W    = 10;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

endpackage

// File: rtl/in_buffer_sdp_ram.sv
// Simple dual-port block RAM: one write port, one read port with a registered output.
module sdp_ram
  import editing_accel_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/in_buffer.sv
// Frame-capture input stage: fills a RAM from an AXI4-Stream slave, then replays it as a gap-free burst.
// Optional macro IN_BUFFER_PAD_EN: pad short frames with zeros out to FRAME_LEN words.
module in_buffer
  import editing_accel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [3:0]        s_axis_tstrb,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              core_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              valid_q, olast_q;
  logic [ADDR_W-1:0] drain_last;
  logic [DATA_W-1:0] ram_rdata;
  logic              beat, rd_en;
  logic              unused_tstrb;

  assign unused_tstrb  = ^s_axis_tstrb;
  assign s_axis_tready = (state_q == FILL) && !rst;
  assign beat          = s_axis_tvalid && s_axis_tready;
  // done_q marks the out_last cycle: reading has stopped but FILL must wait one more cycle
  assign rd_en         = (state_q == DRAIN) && !done_q;

`ifdef IN_BUFFER_PAD_EN
  logic pad_q;
  assign drain_last = LAST_IDX;
`else
  assign drain_last = last_q;
`endif

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      FILL: begin
        if (beat) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (s_axis_tlast || (wr_cnt_q == LAST_IDX)) begin
            last_d   = wr_cnt_q;
            wr_cnt_d = '0;
            state_d  = WAIT;
            if (!s_axis_tlast) err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (core_ready) begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
          done_d   = 1'b0;
        end
      end
      DRAIN: begin
        if (done_q) begin
          state_d = FILL;
          done_d  = 1'b0;
        end else if (rd_ptr_q == drain_last) begin
          done_d = 1'b1;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
      valid_q  <= rd_en;
      olast_q  <= rd_en && (rd_ptr_q == drain_last);
    end
  end

  sdp_ram #(
    .WIDTH (DATA_W),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (beat),
    .waddr (wr_cnt_q),
    .wdata (s_axis_tdata),
    .re    (rd_en),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

`ifdef IN_BUFFER_PAD_EN
  always_ff @(posedge clk) begin
    if (rst) pad_q <= 1'b0;
    else     pad_q <= rd_en && (rd_ptr_q > last_q);
  end
  assign out_data = (valid_q && !pad_q) ? ram_rdata : '0;
`else
  assign out_data = valid_q ? ram_rdata : '0;
`endif

  assign out_valid = valid_q;
  assign out_last  = olast_q;
  assign busy      = (state_q != FILL);
  assign frame_err = err_q;

endmodule
